mem_arbiter: RTL and testbench

Two-master, one-slave arbiter that shares the single backing-memory `Mem_ift` port between the instruction cache and the data cache. Sits between the cache wrappers and the memory/bus model, above both caches' miss/writeback engines. Serialises whole transactions: a grant is held from request handshake until reply handshake, so the memory side sees exactly one outstanding access at a time.

---
 rtl/mem_arbiter_pkg.sv | 26 ++
 rtl/mem_ift.sv | 39 +++
 rtl/mem_arbiter_pick.sv | 21 ++
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-master memory arbiter: FSM state encoding and grant bit indices.
package MemArbStruct;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        I_RD = 2'd1,
        D_RD = 2'd2,
        D_WR = 2'd3
    } arb_state_e;

    localparam int GNT_ICACHE = 0;
    localparam int GNT_DCACHE = 1;

    // One-hot owner vector for a given FSM state; IDLE owns nothing.
    function automatic logic [1:0] state_to_grant(arb_state_e s);
        logic [1:0] g;
        g = 2'b00;
        case (s)
            I_RD:       g[GNT_ICACHE] = 1'b1;
            D_RD, D_WR: g[GNT_DCACHE] = 1'b1;
            default:    g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/mem_ift.sv
// Valid/ready memory port: read request, read reply, write request, write reply channels.
interface Mem_ift #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);

    logic                      rd_req_valid;
    logic                      rd_req_ready;
    logic [ADDR_WIDTH-1:0]     rd_req_addr;

    logic                      rd_rsp_valid;
    logic                      rd_rsp_ready;
    logic [DATA_WIDTH-1:0]     rd_rsp_data;

    logic                      wr_req_valid;
    logic                      wr_req_ready;
    logic [ADDR_WIDTH-1:0]     wr_req_addr;
    logic [DATA_WIDTH-1:0]     wr_req_data;
    logic [DATA_WIDTH/8-1:0]   wr_req_wmask;

    logic                      wr_rsp_valid;
    logic                      wr_rsp_ready;

    // Master issues requests and accepts replies.
    modport Master (
        output rd_req_valid, rd_req_addr, rd_rsp_ready,
        output wr_req_valid, wr_req_addr, wr_req_data, wr_req_wmask, wr_rsp_ready,
        input  rd_req_ready, rd_rsp_valid, rd_rsp_data,
        input  wr_req_ready, wr_rsp_valid
    );

    modport Slave (
        input  rd_req_valid, rd_req_addr, rd_rsp_ready,
        input  wr_req_valid, wr_req_addr, wr_req_data, wr_req_wmask, wr_rsp_ready,
        output rd_req_ready, rd_rsp_valid, rd_rsp_data,
        output wr_req_ready, wr_rsp_valid
    );

endinterface

// File: rtl/mem_arbiter_pick.sv
// Combinational Icache/Dcache picker. Define MEM_ARB_RR_EN for round-robin; otherwise Dcache has fixed priority.
module mem_arb_pick (
    input  logic req_icache,
    input  logic req_dcache,
    input  logic last_grant,
    output logic pick_valid,
    output logic pick_dcache
);

    assign pick_valid = req_icache | req_dcache;

`ifdef MEM_ARB_RR_EN
    // On contention hand the port to whoever did not own it last (last_grant: 1 = Dcache).
    assign pick_dcache = req_dcache & (~req_icache | ~last_grant);
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign pick_dcache       = req_dcache;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Serialising arbiter sharing one Mem_ift memory port between Icache (reads) and Dcache (reads/writes).
// Arbitration policy comes from mem_arb_pick; MEM_ARB_RR_EN selects round-robin instead of Dcache priority.
module mem_arbiter
    import MemArbStruct::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    Mem_ift.Slave       icache_ift,
    Mem_ift.Slave       dcache_ift,
    Mem_ift.Master      mem_ift,
    output logic [1:0]  grant,
    output logic        busy
);

    localparam logic [ADDR_WIDTH-1:0]   ADDR_ZERO = '0;
    localparam logic [DATA_WIDTH-1:0]   DATA_ZERO = '0;
    localparam logic [DATA_WIDTH/8-1:0] MASK_ZERO = '0;

    arb_state_e state_q, state_d;
    logic       last_grant_q, last_grant_d;

    logic       pick_valid;
    logic       pick_dcache;
    logic       dcache_req;

    assign dcache_req = dcache_ift.rd_req_valid | dcache_ift.wr_req_valid;

    mem_arb_pick u_pick (
        .req_icache  (icache_ift.rd_req_valid),
        .req_dcache  (dcache_req),
        .last_grant  (last_grant_q),
        .pick_valid  (pick_valid),
        .pick_dcache (pick_dcache)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // The grant is released only by the reply handshake, never by the request handshake.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    last_grant_d = pick_dcache;
                    if (!pick_dcache) begin
                        state_d = I_RD;
                    end else if (dcache_ift.wr_req_valid) begin
                        state_d = D_WR;
                    end else begin
                        state_d = D_RD;
                    end
                end
            end
            I_RD: begin
                if (mem_ift.rd_rsp_valid && icache_ift.rd_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            D_RD: begin
                if (mem_ift.rd_rsp_valid && dcache_ift.rd_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            D_WR: begin
                if (mem_ift.wr_rsp_valid && dcache_ift.wr_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant = state_to_grant(state_q);
    assign busy  = (state_q != IDLE);

    always_comb begin
        icache_ift.rd_req_ready = 1'b0;
        icache_ift.rd_rsp_valid = 1'b0;
        icache_ift.rd_rsp_data  = DATA_ZERO;
        icache_ift.wr_req_ready = 1'b0;
        icache_ift.wr_rsp_valid = 1'b0;

        dcache_ift.rd_req_ready = 1'b0;
        dcache_ift.rd_rsp_valid = 1'b0;
        dcache_ift.rd_rsp_data  = DATA_ZERO;
        dcache_ift.wr_req_ready = 1'b0;
        dcache_ift.wr_rsp_valid = 1'b0;

        mem_ift.rd_req_valid = 1'b0;
        mem_ift.rd_req_addr  = ADDR_ZERO;
        mem_ift.rd_rsp_ready = 1'b0;
        mem_ift.wr_req_valid = 1'b0;
        mem_ift.wr_req_addr  = ADDR_ZERO;
        mem_ift.wr_req_data  = DATA_ZERO;
        mem_ift.wr_req_wmask = MASK_ZERO;
        mem_ift.wr_rsp_ready = 1'b0;

        case (state_q)
            I_RD: begin
                mem_ift.rd_req_valid    = icache_ift.rd_req_valid;
                mem_ift.rd_req_addr     = icache_ift.rd_req_addr;
                icache_ift.rd_req_ready = mem_ift.rd_req_ready;
                icache_ift.rd_rsp_valid = mem_ift.rd_rsp_valid;
                icache_ift.rd_rsp_data  = mem_ift.rd_rsp_data;
                mem_ift.rd_rsp_ready    = icache_ift.rd_rsp_ready;
            end
            D_RD: begin
                mem_ift.rd_req_valid    = dcache_ift.rd_req_valid;
                mem_ift.rd_req_addr     = dcache_ift.rd_req_addr;
                dcache_ift.rd_req_ready = mem_ift.rd_req_ready;
                dcache_ift.rd_rsp_valid = mem_ift.rd_rsp_valid;
                dcache_ift.rd_rsp_data  = mem_ift.rd_rsp_data;
                mem_ift.rd_rsp_ready    = dcache_ift.rd_rsp_ready;
            end
            D_WR: begin
                mem_ift.wr_req_valid    = dcache_ift.wr_req_valid;
                mem_ift.wr_req_addr     = dcache_ift.wr_req_addr;
                mem_ift.wr_req_data     = dcache_ift.wr_req_data;
                mem_ift.wr_req_wmask    = dcache_ift.wr_req_wmask;
                dcache_ift.wr_req_ready = mem_ift.wr_req_ready;
                dcache_ift.wr_rsp_valid = mem_ift.wr_rsp_valid;
                mem_ift.wr_rsp_ready    = dcache_ift.wr_rsp_ready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; expectations follow MEM_ARB_RR_EN when it is defined.
module tb_mem_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] grant;
    logic       busy;

    int n_compared;
    int n_mismatched;

    Mem_ift #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) ic_if ();
    Mem_ift #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dc_if ();
    Mem_ift #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) mem_if ();

    mem_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .icache_ift (ic_if),
        .dcache_ift (dc_if),
        .mem_ift    (mem_if),
        .grant      (grant),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change just after the falling edge; outputs are checked 1 time unit later.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        ic_if.rd_req_valid  = 1'b0;
        ic_if.rd_req_addr   = '0;
        ic_if.rd_rsp_ready  = 1'b0;
        ic_if.wr_req_valid  = 1'b0;
        ic_if.wr_req_addr   = '0;
        ic_if.wr_req_data   = '0;
        ic_if.wr_req_wmask  = '0;
        ic_if.wr_rsp_ready  = 1'b0;
        dc_if.rd_req_valid  = 1'b0;
        dc_if.rd_req_addr   = '0;
        dc_if.rd_rsp_ready  = 1'b0;
        dc_if.wr_req_valid  = 1'b0;
        dc_if.wr_req_addr   = '0;
        dc_if.wr_req_data   = '0;
        dc_if.wr_req_wmask  = '0;
        dc_if.wr_rsp_ready  = 1'b0;
        mem_if.rd_req_ready = 1'b0;
        mem_if.rd_rsp_valid = 1'b0;
        mem_if.rd_rsp_data  = '0;
        mem_if.wr_req_ready = 1'b0;
        mem_if.wr_rsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        #1;
        n_compared++; if (grant !== 2'b00) begin n_mismatched++; $display("[TB] FAIL reset_grant: got %b want 00", grant); end
        n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        n_compared++; if (mem_if.rd_req_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_mem_rd_valid: got %b want 0", mem_if.rd_req_valid); end
        n_compared++; if (mem_if.wr_req_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_mem_wr_valid: got %b want 0", mem_if.wr_req_valid); end
        n_compared++; if (mem_if.rd_req_addr !== 64'h0) begin n_mismatched++; $display("[TB] FAIL reset_mem_addr: got %h want 0", mem_if.rd_req_addr); end
        n_compared++; if (ic_if.rd_req_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_ic_ready: got %b want 0", ic_if.rd_req_ready); end
        rst = 1'b0;
    endtask

    task automatic test_icache_read();
        tick();
        ic_if.rd_req_valid = 1'b1;
        ic_if.rd_req_addr  = 64'h0000_0000_8000_0000;
        ic_if.rd_rsp_ready = 1'b1;
        #1;
        n_compared++; if (grant !== 2'b00) begin n_mismatched++; $display("[TB] FAIL icrd_idle_grant: got %b want 00", grant); end
        n_compared++; if (mem_if.rd_req_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL icrd_idle_fwd: got %b want 0", mem_if.rd_req_valid); end
        tick();
        #1;
        n_compared++; if (grant !== 2'b01) begin n_mismatched++; $display("[TB] FAIL icrd_grant1: got %b want 01", grant); end
        n_compared++; if (mem_if.rd_req_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL icrd_mem_valid: got %b want 1", mem_if.rd_req_valid); end
        n_compared++; if (mem_if.rd_req_addr !== 64'h0000_0000_8000_0000) begin n_mismatched++; $display("[TB] FAIL icrd_mem_addr: got %h want 80000000", mem_if.rd_req_addr); end
        mem_if.rd_req_ready = 1'b1;
        #1;
        n_compared++; if (ic_if.rd_req_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL icrd_ready: got %b want 1", ic_if.rd_req_ready); end
        tick();
        ic_if.rd_req_valid  = 1'b0;
        mem_if.rd_req_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_compared++; if (grant !== 2'b01) begin n_mismatched++; $display("[TB] FAIL icrd_hold[%0d]: got %b want 01", i, grant); end
            tick();
        end
        mem_if.rd_rsp_valid = 1'b1;
        mem_if.rd_rsp_data  = 64'h1122_3344_5566_7788;
        #1;
        n_compared++; if (grant !== 2'b01) begin n_mismatched++; $display("[TB] FAIL icrd_reply_grant: got %b want 01", grant); end
        n_compared++; if (ic_if.rd_rsp_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL icrd_rsp_valid: got %b want 1", ic_if.rd_rsp_valid); end
        n_compared++; if (ic_if.rd_rsp_data !== 64'h1122_3344_5566_7788) begin n_mismatched++; $display("[TB] FAIL icrd_rsp_data: got %h want 1122334455667788", ic_if.rd_rsp_data); end
        n_compared++; if (dc_if.rd_rsp_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL icrd_dc_rsp_blocked: got %b want 0", dc_if.rd_rsp_valid); end
        tick();
        mem_if.rd_rsp_valid = 1'b0;
        mem_if.rd_rsp_data  = '0;
        #1;
        n_compared++; if (grant !== 2'b00) begin n_mismatched++; $display("[TB] FAIL icrd_after_grant: got %b want 00", grant); end
        n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL icrd_after_busy: got %b want 0", busy); end
        clear_inputs();
    endtask

    task automatic test_write_before_read();
        tick();
        dc_if.wr_req_valid = 1'b1;
        dc_if.wr_req_addr  = 64'h100;
        dc_if.wr_req_data  = 64'hDEAD_BEEF_CAFE_F00D;
        dc_if.wr_req_wmask = 8'hFF;
        dc_if.wr_rsp_ready = 1'b1;
        dc_if.rd_req_valid = 1'b1;
        dc_if.rd_req_addr  = 64'h100;
        dc_if.rd_rsp_ready = 1'b1;
        tick();
        #1;
        n_compared++; if (grant !== 2'b10) begin n_mismatched++; $display("[TB] FAIL dwr_grant: got %b want 10", grant); end
        n_compared++; if (mem_if.wr_req_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL dwr_mem_wr_valid: got %b want 1", mem_if.wr_req_valid); end
        n_compared++; if (mem_if.rd_req_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL dwr_mem_rd_valid: got %b want 0", mem_if.rd_req_valid); end
        n_compared++; if (mem_if.wr_req_data !== 64'hDEAD_BEEF_CAFE_F00D) begin n_mismatched++; $display("[TB] FAIL dwr_mem_data: got %h want deadbeefcafef00d", mem_if.wr_req_data); end
        n_compared++; if (mem_if.wr_req_wmask !== 8'hFF) begin n_mismatched++; $display("[TB] FAIL dwr_mem_mask: got %h want ff", mem_if.wr_req_wmask); end
        mem_if.wr_req_ready = 1'b1;
        mem_if.wr_rsp_valid = 1'b1;
        #1;
        n_compared++; if (dc_if.wr_req_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL dwr_wr_ready: got %b want 1", dc_if.wr_req_ready); end
        n_compared++; if (dc_if.wr_rsp_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL dwr_wr_rsp: got %b want 1", dc_if.wr_rsp_valid); end
        n_compared++; if (dc_if.rd_req_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL dwr_rd_ready: got %b want 0", dc_if.rd_req_ready); end
        tick();
        dc_if.wr_req_valid  = 1'b0;
        mem_if.wr_req_ready = 1'b0;
        mem_if.wr_rsp_valid = 1'b0;
        #1;
        n_compared++; if (grant !== 2'b00) begin n_mismatched++; $display("[TB] FAIL drd_gap_grant: got %b want 00", grant); end
        n_compared++; if (mem_if.rd_req_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL drd_gap_fwd: got %b want 0", mem_if.rd_req_valid); end
        tick();
        #1;
        n_compared++; if (grant !== 2'b10) begin n_mismatched++; $display("[TB] FAIL drd_grant: got %b want 10", grant); end
        n_compared++; if (mem_if.rd_req_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL drd_mem_valid: got %b want 1", mem_if.rd_req_valid); end
        n_compared++; if (mem_if.wr_req_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL drd_mem_wr_valid: got %b want 0", mem_if.wr_req_valid); end
        mem_if.rd_req_ready = 1'b1;
        mem_if.rd_rsp_valid = 1'b1;
        mem_if.rd_rsp_data  = 64'hA5A5_0000_0000_5A5A;
        #1;
        n_compared++; if (dc_if.rd_rsp_data !== 64'hA5A5_0000_0000_5A5A) begin n_mismatched++; $display("[TB] FAIL drd_rsp_data: got %h want a5a500000000 5a5a", dc_if.rd_rsp_data); end
        tick();
        clear_inputs();
        #1;
        n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL drd_done_busy: got %b want 0", busy); end
    endtask

    task automatic test_contention();
        logic [1:0] want;
        rst = 1'b1;
        clear_inputs();
        tick();
        rst = 1'b0;
        ic_if.rd_req_valid = 1'b1;
        ic_if.rd_req_addr  = 64'h2000;
        ic_if.rd_rsp_ready = 1'b1;
        dc_if.rd_req_valid = 1'b1;
        dc_if.rd_req_addr  = 64'h3000;
        dc_if.rd_rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
            want = (i % 2 == 0) ? 2'b10 : 2'b01;
`else
            want = 2'b10;
`endif
            #1;
            n_compared++; if (grant !== 2'b00) begin n_mismatched++; $display("[TB] FAIL cont_idle[%0d]: got %b want 00", i, grant); end
            tick();
            #1;
            n_compared++; if (grant !== want) begin n_mismatched++; $display("[TB] FAIL cont_grant[%0d]: got %b want %b", i, grant, want); end
            mem_if.rd_req_ready = 1'b1;
            mem_if.rd_rsp_valid = 1'b1;
            mem_if.rd_rsp_data  = 64'h0 + i + 1;
            #1;
            n_compared++; if (dc_if.rd_rsp_valid !== want[1]) begin n_mismatched++; $display("[TB] FAIL cont_dc_rsp[%0d]: got %b want %b", i, dc_if.rd_rsp_valid, want[1]); end
            n_compared++; if (ic_if.rd_rsp_valid !== want[0]) begin n_mismatched++; $display("[TB] FAIL cont_ic_rsp[%0d]: got %b want %b", i, ic_if.rd_rsp_valid, want[0]); end
            tick();
            mem_if.rd_req_ready = 1'b0;
            mem_if.rd_rsp_valid = 1'b0;
            mem_if.rd_rsp_data  = '0;
        end
        dc_if.rd_req_valid = 1'b0;
        tick();
        #1;
        n_compared++; if (grant !== 2'b01) begin n_mismatched++; $display("[TB] FAIL cont_ic_last: got %b want 01", grant); end
        n_compared++; if (mem_if.rd_req_addr !== 64'h2000) begin n_mismatched++; $display("[TB] FAIL cont_ic_addr: got %h want 2000", mem_if.rd_req_addr); end
        mem_if.rd_req_ready = 1'b1;
        mem_if.rd_rsp_valid = 1'b1;
        tick();
        clear_inputs();
    endtask

    task automatic test_icache_write();
        tick();
        ic_if.wr_req_valid = 1'b1;
        ic_if.wr_req_addr  = 64'h4000;
        ic_if.wr_req_data  = 64'h1234;
        ic_if.wr_req_wmask = 8'hFF;
        ic_if.wr_rsp_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            n_compared++; if (ic_if.wr_req_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL icwr_ready[%0d]: got %b want 0", i, ic_if.wr_req_ready); end
            n_compared++; if (mem_if.wr_req_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL icwr_mem_valid[%0d]: got %b want 0", i, mem_if.wr_req_valid); end
            tick();
        end
        #1;
        n_compared++; if (grant !== 2'b00) begin n_mismatched++; $display("[TB] FAIL icwr_grant: got %b want 00", grant); end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        logic [1:0] want;
        tick();
        ic_if.rd_req_valid  = 1'b1;
        ic_if.rd_req_addr   = 64'h5000;
        ic_if.rd_rsp_ready  = 1'b1;
        mem_if.rd_req_ready = 1'b1;
        mem_if.rd_rsp_valid = 1'b1;
        mem_if.rd_rsp_data  = 64'h77;
        for (int i = 0; i < 8; i++) begin
            want = (i % 2 == 1) ? 2'b01 : 2'b00;
            #1;
            n_compared++; if (grant !== want) begin n_mismatched++; $display("[TB] FAIL zl_grant[%0d]: got %b want %b", i, grant, want); end
            n_compared++; if (busy !== want[0]) begin n_mismatched++; $display("[TB] FAIL zl_busy[%0d]: got %b want %b", i, busy, want[0]); end
            tick();
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        dc_if.rd_req_valid = 1'b1;
        dc_if.rd_req_addr  = 64'h6000;
        dc_if.rd_rsp_ready = 1'b1;
        tick();
        #1;
        n_compared++; if (grant !== 2'b10) begin n_mismatched++; $display("[TB] FAIL rstmid_grant: got %b want 10", grant); end
        rst = 1'b1;
        tick();
        #1;
        n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rstmid_busy: got %b want 0", busy); end
        n_compared++; if (grant !== 2'b00) begin n_mismatched++; $display("[TB] FAIL rstmid_grant0: got %b want 00", grant); end
        n_compared++; if (mem_if.rd_req_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rstmid_mem_valid: got %b want 0", mem_if.rd_req_valid); end
        rst = 1'b0;
        clear_inputs();
        ic_if.rd_req_valid = 1'b1;
        ic_if.rd_req_addr  = 64'h7000;
        ic_if.rd_rsp_ready = 1'b1;
        tick();
        #1;
        n_compared++; if (grant !== 2'b01) begin n_mismatched++; $display("[TB] FAIL rstmid_ic_grant: got %b want 01", grant); end
        mem_if.rd_req_ready = 1'b1;
        mem_if.rd_rsp_valid = 1'b1;
        mem_if.rd_rsp_data  = 64'hFEED_0000_0000_BEEF;
        #1;
        n_compared++; if (ic_if.rd_rsp_data !== 64'hFEED_0000_0000_BEEF) begin n_mismatched++; $display("[TB] FAIL rstmid_ic_data: got %h want feed00000000beef", ic_if.rd_rsp_data); end
        tick();
        clear_inputs();
        #1;
        n_compared++; if (grant !== 2'b00) begin n_mismatched++; $display("[TB] FAIL rstmid_final_grant: got %b want 00", grant); end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst          = 1'b1;
        clear_inputs();
        test_reset();
        test_icache_read();
        test_write_before_read();
        test_contention();
        test_icache_write();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
